// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester handshakes plus the memory-side bus, seen from the arbiter (slave)
// and from the environment that holds the requesters and the memory (master).
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_out;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output ack0, ack1, rdata0, rdata1, mem_write, mem_address, mem_data, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  ack0, ack1, rdata0, rdata1, mem_write, mem_address, mem_data, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way combinational picker: single requester wins outright, ties go
// round-robin (away from last_grant) or to port 0 when rr_en is low.
module rr_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic rr_en,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = PORT0;
    if (req0 && req1) begin
      grant_id = rr_en ? ~last_grant : PORT0;
    end else if (req1) begin
      grant_id = PORT1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two req/ack requesters:
// IDLE -> ACCESS -> RESP, one access every three cycles.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RR_EN  = 1
)
(
  input  logic              clock,
  input  logic              reset_n,
  data_mem_arbiter_if.slave bus
);

  localparam logic RR_BIT = (RR_EN != 0);

  state_t            state;
  logic              last_grant;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              ack0_reg;
  logic              ack1_reg;
  logic              busy_reg;
  logic [DATA_W-1:0] rdata0_reg;
  logic [DATA_W-1:0] rdata1_reg;
  logic              grant_valid;
  logic              grant_id;

  rr_pick2 u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_grant  (last_grant),
    .rr_en       (RR_BIT),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // last_grant doubles as the owner of the access in flight during ACCESS/RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= PORT1;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_id;
            we_reg     <= (grant_id == PORT1) ? bus.we1    : bus.we0;
            addr_reg   <= (grant_id == PORT1) ? bus.addr1  : bus.addr0;
            wdata_reg  <= (grant_id == PORT1) ? bus.wdata1 : bus.wdata0;
            busy_reg   <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_reg) begin
            if (last_grant == PORT1) rdata1_reg <= bus.mem_out;
            else                     rdata0_reg <= bus.mem_out;
          end
          ack0_reg <= (last_grant == PORT0);
          ack1_reg <= (last_grant == PORT1);
          state    <= RESP;
        end
        RESP: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Decoded from state so an asynchronous reset withdraws a write at once.
  assign bus.mem_write   = (state == ACCESS) && we_reg;
  assign bus.mem_address = addr_reg;
  assign bus.mem_data    = wdata_reg;
  assign bus.ack0        = ack0_reg;
  assign bus.ack1        = ack1_reg;
  assign bus.rdata0      = rdata0_reg;
  assign bus.rdata1      = rdata1_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: a round-robin instance (bus_a) and a fixed-priority instance
// (bus_b), each in front of its own 256x8 behavioural memory.
module tb_data_mem_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  bit   loaded_a;
  bit   loaded_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(0)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus_a.mem_out = mem_a[bus_a.mem_address];
  assign bus_b.mem_out = mem_b[bus_b.mem_address];

  always @(posedge clock) begin
    if (!reset_n && !loaded_a) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
      mem_a[1]   <= 8'h11;
      mem_a[2]   <= 8'h22;
      mem_a[60]  <= 8'h66;
      mem_a[71]  <= 8'h77;
      mem_a[100] <= 8'd10;
      loaded_a   <= 1'b1;
    end else if (bus_a.mem_write) begin
      mem_a[bus_a.mem_address] <= bus_a.mem_data;
    end
  end

  always @(posedge clock) begin
    if (!reset_n && !loaded_b) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      mem_b[1] <= 8'h11;
      mem_b[2] <= 8'h22;
      loaded_b <= 1'b1;
    end else if (bus_b.mem_write) begin
      mem_b[bus_b.mem_address] <= bus_b.mem_data;
    end
  end

  // Running protocol checks on both instances.
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if (bus_a.ack0 && bus_a.ack1) begin
        errors++;
        $display("FAIL mon_a_dual_ack: ack0=%b ack1=%b required not both 1", bus_a.ack0, bus_a.ack1);
      end
      checks++;
      if (bus_a.mem_write && !bus_a.busy) begin
        errors++;
        $display("FAIL mon_a_write_idle: mem_write=%b busy=%b required write only while busy", bus_a.mem_write, bus_a.busy);
      end
      checks++;
      if (bus_b.ack0 && bus_b.ack1) begin
        errors++;
        $display("FAIL mon_b_dual_ack: ack0=%b ack1=%b required not both 1", bus_b.ack0, bus_b.ack1);
      end
    end
  end

  task automatic drop_all();
    bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
    bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drop_all();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Runs one access on bus_a; called 1 time unit after a rising edge.
  task automatic access_a(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, output int lat, output logic [7:0] rd,
                          output int other_acks, output int wr_cycles, output int busy_cycles);
    bit got;
    got = 0; lat = -1; rd = 8'h00; other_acks = 0; wr_cycles = 0; busy_cycles = 0;
    if (port) begin
      bus_a.req1 = 1; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
    end else begin
      bus_a.req0 = 1; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
    end
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clock);
      if (bus_a.mem_write) wr_cycles++;
      if (bus_a.busy) busy_cycles++;
      if (port ? bus_a.ack0 : bus_a.ack1) other_acks++;
      if (port ? bus_a.ack1 : bus_a.ack0) begin
        got = 1;
        lat = i;
        rd  = port ? bus_a.rdata1 : bus_a.rdata0;
      end
    end
    @(posedge clock);
    #1;
    if (port) begin bus_a.req1 = 0; bus_a.we1 = 0; end
    else      begin bus_a.req0 = 0; bus_a.we0 = 0; end
    $display("access port=%0d we=%0d addr=%0d wdata=%h lat=%0d rdata=%h", port, we, addr, wdata, lat, rd);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_a.ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", bus_a.ack0); end
    checks++; if (bus_a.ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b want 0", bus_a.ack1); end
    checks++; if (bus_a.rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata0: got %h want 00", bus_a.rdata0); end
    checks++; if (bus_a.rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata1: got %h want 00", bus_a.rdata1); end
    checks++; if (bus_a.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus_a.mem_write); end
    checks++; if (bus_a.mem_address !== 8'h00) begin errors++; $display("FAIL reset_mem_address: got %h want 00", bus_a.mem_address); end
    checks++; if (bus_a.mem_data !== 8'h00) begin errors++; $display("FAIL reset_mem_data: got %h want 00", bus_a.mem_data); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    $display("reset done: outputs checked");
  endtask

  task automatic test_read();
    int lat, oth, wr, bsy;
    logic [7:0] rd;
    access_a(1'b0, 1'b0, 8'd100, 8'h00, lat, rd, oth, wr, bsy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++; if (rd !== 8'd10) begin errors++; $display("FAIL read_rdata0: got %h want 0a", rd); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL read_ack1: got %0d pulses want 0", oth); end
    checks++; if (wr !== 0) begin errors++; $display("FAIL read_mem_write: got %0d cycles want 0", wr); end
    checks++; if (bsy !== 2) begin errors++; $display("FAIL read_busy: got %0d cycles want 2", bsy); end
  endtask

  task automatic test_write_read();
    int lat, oth, wr, bsy;
    logic [7:0] rd;
    access_a(1'b1, 1'b1, 8'd50, 8'hA5, lat, rd, oth, wr, bsy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    checks++; if (wr !== 1) begin errors++; $display("FAIL write_mem_write: got %0d cycles want 1", wr); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_rdata1_hold: got %h want 00", rd); end
    checks++; if (mem_a[50] !== 8'hA5) begin errors++; $display("FAIL write_mem50: got %h want a5", mem_a[50]); end
    access_a(1'b1, 1'b0, 8'd50, 8'h00, lat, rd, oth, wr, bsy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL readback_latency: got %0d want 3", lat); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL readback_rdata1: got %h want a5", rd); end
    checks++; if (wr !== 0) begin errors++; $display("FAIL readback_mem_write: got %0d cycles want 0", wr); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL readback_ack0: got %0d pulses want 0", oth); end
  endtask

  task automatic test_round_robin();
    int qa[$];
    int qb[$];
    int got_id;
    do_reset();
    bus_a.req0 = 1; bus_a.req1 = 1; bus_a.addr0 = 8'd1; bus_a.addr1 = 8'd2;
    bus_b.req0 = 1; bus_b.req1 = 1; bus_b.addr0 = 8'd1; bus_b.addr1 = 8'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus_a.ack0) qa.push_back(0);
      if (bus_a.ack1) qa.push_back(1);
      if (bus_b.ack0) qb.push_back(0);
      if (bus_b.ack1) qb.push_back(1);
    end
    @(posedge clock);
    #1 drop_all();
    checks++; if (qa.size() !== 4) begin errors++; $display("FAIL rr_count: got %0d grants want 4", qa.size()); end
    for (int k = 0; k < 4; k++) begin
      got_id = (k < qa.size()) ? qa[k] : 9;
      checks++; if (got_id !== (k % 2)) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, got_id, k % 2); end
    end
    checks++; if (qb.size() !== 4) begin errors++; $display("FAIL fixed_count: got %0d grants want 4", qb.size()); end
    for (int k = 0; k < 4; k++) begin
      got_id = (k < qb.size()) ? qb[k] : 9;
      checks++; if (got_id !== 0) begin errors++; $display("FAIL fixed_grant%0d: got %0d want 0", k, got_id); end
    end
    checks++; if (bus_a.rdata0 !== 8'h11) begin errors++; $display("FAIL rr_rdata0: got %h want 11", bus_a.rdata0); end
    checks++; if (bus_a.rdata1 !== 8'h22) begin errors++; $display("FAIL rr_rdata1: got %h want 22", bus_a.rdata1); end
    checks++; if (bus_b.rdata1 !== 8'h00) begin errors++; $display("FAIL fixed_rdata1: got %h want 00", bus_b.rdata1); end
    $display("round robin: rr grants=%0d fixed grants=%0d", qa.size(), qb.size());
  endtask

  task automatic test_latch_and_drop();
    int n0, n1;
    n0 = 0; n1 = 0;
    bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 8'd70; bus_a.wdata0 = 8'h3C;
    @(posedge clock);
    #1;
    bus_a.req0 = 0; bus_a.we0 = 0; bus_a.addr0 = 8'd71; bus_a.wdata0 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus_a.ack0) n0++;
      if (bus_a.ack1) n1++;
    end
    checks++; if (n0 !== 1) begin errors++; $display("FAIL drop_ack0: got %0d pulses want 1", n0); end
    checks++; if (n1 !== 0) begin errors++; $display("FAIL drop_ack1: got %0d pulses want 0", n1); end
    checks++; if (mem_a[70] !== 8'h3C) begin errors++; $display("FAIL latch_mem70: got %h want 3c", mem_a[70]); end
    checks++; if (mem_a[71] !== 8'h77) begin errors++; $display("FAIL latch_mem71: got %h want 77", mem_a[71]); end
    checks++; if (bus_a.mem_address !== 8'd70) begin errors++; $display("FAIL latch_addr_hold: got %0d want 70", bus_a.mem_address); end
    $display("latch/drop: ack0 pulses=%0d mem70=%h", n0, mem_a[70]);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int n, lat, oth, wr, bsy;
    logic [7:0] rd;
    n = 0;
    bus_a.req1 = 1; bus_a.we1 = 1; bus_a.addr1 = 8'd60; bus_a.wdata1 = 8'h99;
    @(posedge clock);
    #2;
    checks++; if (bus_a.mem_write !== 1'b1) begin errors++; $display("FAIL mid_write_active: got %b want 1", bus_a.mem_write); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus_a.mem_write !== 1'b0) begin errors++; $display("FAIL mid_write_drop: got %b want 0", bus_a.mem_write); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus_a.busy); end
    checks++; if (bus_a.rdata1 !== 8'h00) begin errors++; $display("FAIL mid_rdata1: got %h want 00", bus_a.rdata1); end
    checks++; if (bus_a.rdata0 !== 8'h00) begin errors++; $display("FAIL mid_rdata0: got %h want 00", bus_a.rdata0); end
    checks++; if (bus_a.mem_address !== 8'h00) begin errors++; $display("FAIL mid_mem_address: got %h want 00", bus_a.mem_address); end
    checks++; if (bus_a.mem_data !== 8'h00) begin errors++; $display("FAIL mid_mem_data: got %h want 00", bus_a.mem_data); end
    bus_a.req1 = 0; bus_a.we1 = 0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus_a.ack0 || bus_a.ack1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d pulses want 0", n); end
    checks++; if (mem_a[60] !== 8'h66) begin errors++; $display("FAIL mid_mem60: got %h want 66", mem_a[60]); end
    $display("reset mid-access: acks=%0d mem60=%h", n, mem_a[60]);
    @(posedge clock);
    #1;
    access_a(1'b0, 1'b0, 8'd60, 8'h00, lat, rd, oth, wr, bsy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL after_reset_latency: got %0d want 3", lat); end
    checks++; if (rd !== 8'h66) begin errors++; $display("FAIL after_reset_rdata0: got %h want 66", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    loaded_a = 0;
    loaded_b = 0;
    reset_n = 1'b0;
    bus_a.addr0 = 0; bus_a.addr1 = 0; bus_a.wdata0 = 0; bus_a.wdata1 = 0;
    bus_b.addr0 = 0; bus_b.addr1 = 0; bus_b.wdata0 = 0; bus_b.wdata1 = 0;
    drop_all();
    test_reset();
    test_read();
    test_write_read();
    test_round_robin();
    test_latch_and_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
